// File: rtl/vscale_mem_arbiter_pkg.sv
// rtl/vscale_mem_arbiter_pkg.sv - shared constants for the imem/dmem port arbiter
package vscale_mem_arbiter_pkg;

  localparam int XPR_LEN_DEFAULT        = 32;
  localparam int MEM_TYPE_WIDTH_DEFAULT = 3;

  // Access size presented for instruction fetches (full word).
  localparam logic [MEM_TYPE_WIDTH_DEFAULT-1:0] MEM_TYPE_W = 3'd2;

  // Owner of the data phase currently in flight on the shared port.
  localparam logic [1:0] MEM_OWNER_NONE = 2'd0;
  localparam logic [1:0] MEM_OWNER_IMEM = 2'd1;
  localparam logic [1:0] MEM_OWNER_DMEM = 2'd2;

endpackage

// File: rtl/vscale_mem_skid.sv
// rtl/vscale_mem_skid.sv - one-entry capture/replay register for a deferred request
module vscale_mem_skid #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             capture,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic             valid,
  output logic [WIDTH-1:0] dout
);

  // Entry valid flag: a capture wins over a clear; reset drops the entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
    end else if (capture) begin
      valid <= 1'b1;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

  // Payload is only meaningful while valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/vscale_mem_arbiter.sv
// rtl/vscale_mem_arbiter.sv - fixed-priority sharing of one pipelined memory port by imem and dmem
module vscale_mem_arbiter
  import vscale_mem_arbiter_pkg::*;
#(
  parameter int XPR_LEN        = XPR_LEN_DEFAULT,
  parameter int MEM_TYPE_WIDTH = MEM_TYPE_WIDTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [XPR_LEN-1:0]        imem_addr,
  output logic [XPR_LEN-1:0]        imem_rdata,
  output logic                      imem_wait,
  output logic                      imem_badmem_e,
  input  logic                      dmem_en,
  input  logic                      dmem_wen,
  input  logic [MEM_TYPE_WIDTH-1:0] dmem_size,
  input  logic [XPR_LEN-1:0]        dmem_addr,
  input  logic [XPR_LEN-1:0]        dmem_wdata_delayed,
  output logic [XPR_LEN-1:0]        dmem_rdata,
  output logic                      dmem_wait,
  output logic                      dmem_badmem_e,
  output logic                      mem_en,
  output logic                      mem_wen,
  output logic [MEM_TYPE_WIDTH-1:0] mem_size,
  output logic [XPR_LEN-1:0]        mem_addr,
  output logic [XPR_LEN-1:0]        mem_wdata,
  input  logic [XPR_LEN-1:0]        mem_rdata,
  input  logic                      mem_wait,
  input  logic                      mem_badmem_e
);

  localparam int DPEND_W = XPR_LEN + 1 + MEM_TYPE_WIDTH;

  logic [1:0]                dp_owner;
  logic                      advance;
  logic                      live_d;
  logic                      live_i;

  logic                      ipend_valid;
  logic                      ipend_capture;
  logic                      ipend_clear;
  logic [XPR_LEN-1:0]        ipend_addr;

  logic                      dpend_valid;
  logic                      dpend_capture;
  logic                      dpend_clear;
  logic [DPEND_W-1:0]        dpend_data;
  logic [XPR_LEN-1:0]        dpend_addr;
  logic                      dpend_wen;
  logic [MEM_TYPE_WIDTH-1:0] dpend_size;

  logic [1:0]                sel_owner;
  logic                      sel_ipend;
  logic [XPR_LEN-1:0]        sel_addr;
  logic                      sel_wen;
  logic [MEM_TYPE_WIDTH-1:0] sel_size;

  assign {dpend_addr, dpend_wen, dpend_size} = dpend_data;

  // A side waits while its request sits in the pending register or its data phase stalls.
  assign imem_wait = ipend_valid | ((dp_owner == MEM_OWNER_IMEM) & mem_wait);
  assign dmem_wait = dpend_valid | ((dp_owner == MEM_OWNER_DMEM) & mem_wait);

  // Live requests only count when the requester is not already waiting.
  assign live_d  = dmem_en & ~dmem_wait;
  assign live_i  = ~imem_wait;
  assign advance = ~((dp_owner != MEM_OWNER_NONE) & mem_wait);

  // Address-phase source: pending data, live data, pending fetch, live fetch.
  always_comb begin
    sel_owner = MEM_OWNER_NONE;
    sel_ipend = 1'b0;
    sel_addr  = '0;
    sel_wen   = 1'b0;
    sel_size  = '0;
    if (dpend_valid) begin
      sel_owner = MEM_OWNER_DMEM;
      sel_addr  = dpend_addr;
      sel_wen   = dpend_wen;
      sel_size  = dpend_size;
    end else if (live_d) begin
      sel_owner = MEM_OWNER_DMEM;
      sel_addr  = dmem_addr;
      sel_wen   = dmem_wen;
      sel_size  = dmem_size;
    end else if (ipend_valid) begin
      sel_owner = MEM_OWNER_IMEM;
      sel_ipend = 1'b1;
      sel_addr  = ipend_addr;
      sel_size  = MEM_TYPE_W;
    end else if (live_i) begin
      sel_owner = MEM_OWNER_IMEM;
      sel_addr  = imem_addr;
      sel_size  = MEM_TYPE_W;
    end
  end

  assign mem_en   = (sel_owner != MEM_OWNER_NONE) & ~reset;
  assign mem_wen  = sel_wen;
  assign mem_size = sel_size;
  assign mem_addr = sel_addr;

  // An unserved fetch is parked when a data access takes the slot (pending or live,
  // otherwise the fetch would see wait=0 with no data phase) or when the port stalls.
  assign ipend_capture = live_i & (advance ? (sel_owner == MEM_OWNER_DMEM) : 1'b1);
  assign ipend_clear   = advance & sel_ipend;
  assign dpend_capture = ~advance & live_d;
  assign dpend_clear   = advance & dpend_valid;

  vscale_mem_skid #(
    .WIDTH (XPR_LEN)
  ) u_ipend (
    .clk     (clk),
    .reset   (reset),
    .capture (ipend_capture),
    .clear   (ipend_clear),
    .din     (imem_addr),
    .valid   (ipend_valid),
    .dout    (ipend_addr)
  );

  vscale_mem_skid #(
    .WIDTH (DPEND_W)
  ) u_dpend (
    .clk     (clk),
    .reset   (reset),
    .capture (dpend_capture),
    .clear   (dpend_clear),
    .din     ({dmem_addr, dmem_wen, dmem_size}),
    .valid   (dpend_valid),
    .dout    (dpend_data)
  );

  // Data-phase owner follows the accepted address phase and holds through stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      dp_owner <= MEM_OWNER_NONE;
    end else if (advance) begin
      dp_owner <= sel_owner;
    end
  end

  assign imem_rdata    = mem_rdata;
  assign dmem_rdata    = mem_rdata;
  assign mem_wdata     = dmem_wdata_delayed;
  assign imem_badmem_e = mem_badmem_e & (dp_owner == MEM_OWNER_IMEM);
  assign dmem_badmem_e = mem_badmem_e & (dp_owner == MEM_OWNER_DMEM);

endmodule

// File: tb/tb_vscale_mem_arbiter.sv
// tb/tb_vscale_mem_arbiter.sv - scoreboard bench for vscale_mem_arbiter
module tb_vscale_mem_arbiter;

  logic        clk = 1'b1;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_wait;
  logic        imem_badmem_e;
  logic        dmem_en;
  logic        dmem_wen;
  logic [2:0]  dmem_size;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata_delayed;
  logic [31:0] dmem_rdata;
  logic        dmem_wait;
  logic        dmem_badmem_e;
  logic        mem_en;
  logic        mem_wen;
  logic [2:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_wait;
  logic        mem_badmem_e;

  typedef struct {
    logic        en;
    logic [31:0] addr;
    logic        wen;
    logic [2:0]  size;
    logic        iw;
    logic        dw;
    logic        ib;
    logic        db;
    logic [31:0] rdata;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  vscale_mem_arbiter dut (
    .clk                (clk),
    .reset              (reset),
    .imem_addr          (imem_addr),
    .imem_rdata         (imem_rdata),
    .imem_wait          (imem_wait),
    .imem_badmem_e      (imem_badmem_e),
    .dmem_en            (dmem_en),
    .dmem_wen           (dmem_wen),
    .dmem_size          (dmem_size),
    .dmem_addr          (dmem_addr),
    .dmem_wdata_delayed (dmem_wdata_delayed),
    .dmem_rdata         (dmem_rdata),
    .dmem_wait          (dmem_wait),
    .dmem_badmem_e      (dmem_badmem_e),
    .mem_en             (mem_en),
    .mem_wen            (mem_wen),
    .mem_size           (mem_size),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_rdata          (mem_rdata),
    .mem_wait           (mem_wait),
    .mem_badmem_e       (mem_badmem_e)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected in that cycle.
  task automatic step(
    input logic rst, input logic [31:0] ia, input logic de, input logic dwe,
    input logic [31:0] da, input logic [31:0] wd, input logic [31:0] rd,
    input logic mw, input logic mb,
    input logic ee, input logic [31:0] ea, input logic ew, input logic [2:0] es,
    input logic eiw, input logic edw, input logic eib, input logic edb);
    exp_t e;
    reset              = rst;
    imem_addr          = ia;
    dmem_en            = de;
    dmem_wen           = dwe;
    dmem_addr          = da;
    dmem_wdata_delayed = wd;
    mem_rdata          = rd;
    mem_wait           = mw;
    mem_badmem_e       = mb;
    e.en = ee; e.addr = ea; e.wen = ew; e.size = es;
    e.iw = eiw; e.dw = edw; e.ib = eib; e.db = edb;
    e.rdata = rd; e.wdata = wd;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the DUT against the oldest queued expectation, away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mem_en", {31'd0, mem_en}, {31'd0, e.en});
        chk("imem_wait", {31'd0, imem_wait}, {31'd0, e.iw});
        chk("dmem_wait", {31'd0, dmem_wait}, {31'd0, e.dw});
        chk("imem_badmem_e", {31'd0, imem_badmem_e}, {31'd0, e.ib});
        chk("dmem_badmem_e", {31'd0, dmem_badmem_e}, {31'd0, e.db});
        chk("imem_rdata", imem_rdata, e.rdata);
        chk("dmem_rdata", dmem_rdata, e.rdata);
        chk("mem_wdata", mem_wdata, e.wdata);
        if (e.en) begin
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_wen", {31'd0, mem_wen}, {31'd0, e.wen});
          chk("mem_size", {29'd0, mem_size}, {29'd0, e.size});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    dmem_size          = 3'd0;
    reset              = 1'b1;
    imem_addr          = 32'h200;
    dmem_en            = 1'b0;
    dmem_wen           = 1'b0;
    dmem_addr          = 32'h0;
    dmem_wdata_delayed = 32'h0;
    mem_rdata          = 32'h0;
    mem_wait           = 1'b0;
    mem_badmem_e       = 1'b0;
    @(posedge clk);
    #1;
    //    rst ia       de dwe da        wd            rd            mw mb | en addr     wen sz iw dw ib db
    step(1, 32'h200, 0, 0, 32'h0,    32'h0,        32'h000000A0, 1, 1,   0, 32'h0,    0, 0, 0, 0, 0, 0);
    // idle then fetch
    step(0, 32'h200, 0, 0, 32'h0,    32'h0,        32'h000000A1, 0, 0,   1, 32'h200,  0, 2, 0, 0, 0, 0);
    // simultaneous fetch and load: load first, fetch deferred one cycle
    step(0, 32'h204, 1, 0, 32'h1000, 32'h0,        32'h11111111, 0, 0,   1, 32'h1000, 0, 0, 0, 0, 0, 0);
    step(0, 32'h204, 0, 0, 32'h0,    32'h0,        32'h22222222, 0, 0,   1, 32'h204,  0, 2, 1, 0, 0, 0);
    // store address phase, then its data phase
    step(0, 32'h208, 1, 1, 32'h1004, 32'h0,        32'h33333333, 0, 0,   1, 32'h1004, 1, 0, 0, 0, 0, 0);
    step(0, 32'h208, 0, 0, 32'h0,    32'hDEADBEEF, 32'h44444444, 0, 0,   1, 32'h208,  0, 2, 1, 0, 0, 0);
    // load blocked behind a 3-cycle fetch stall, replayed when mem_wait falls
    step(0, 32'h20C, 1, 0, 32'h2000, 32'h0,        32'h0,        1, 0,   1, 32'h2000, 0, 0, 1, 0, 0, 0);
    step(0, 32'h20C, 0, 0, 32'h0,    32'h0,        32'h0,        1, 0,   1, 32'h2000, 0, 0, 1, 1, 0, 0);
    step(0, 32'h20C, 0, 0, 32'h0,    32'h0,        32'h0,        1, 0,   1, 32'h2000, 0, 0, 1, 1, 0, 0);
    step(0, 32'h20C, 0, 0, 32'h0,    32'h0,        32'h55555555, 0, 0,   1, 32'h2000, 0, 0, 0, 1, 0, 0);
    step(0, 32'h20C, 0, 0, 32'h0,    32'h0,        32'h66666666, 0, 0,   1, 32'h20C,  0, 2, 1, 0, 0, 0);
    // error attribution: fetch owner, then data owner with a fetch pending
    step(0, 32'h210, 0, 0, 32'h0,    32'h0,        32'h77777777, 0, 1,   1, 32'h210,  0, 2, 0, 0, 1, 0);
    step(0, 32'h214, 1, 0, 32'h3000, 32'h0,        32'h0,        0, 0,   1, 32'h3000, 0, 0, 0, 0, 0, 0);
    step(0, 32'h214, 0, 0, 32'h0,    32'h0,        32'h0,        0, 1,   1, 32'h214,  0, 2, 1, 0, 0, 1);
    // back-to-back loads starve fetch until the first gap
    step(0, 32'h218, 1, 0, 32'h4000, 32'h0,        32'h0,        0, 0,   1, 32'h4000, 0, 0, 0, 0, 0, 0);
    step(0, 32'h218, 1, 0, 32'h4004, 32'h0,        32'h0,        0, 0,   1, 32'h4004, 0, 0, 1, 0, 0, 0);
    step(0, 32'h218, 1, 0, 32'h4008, 32'h0,        32'h0,        0, 0,   1, 32'h4008, 0, 0, 1, 0, 0, 0);
    step(0, 32'h218, 0, 0, 32'h0,    32'h0,        32'h0,        0, 0,   1, 32'h218,  0, 2, 1, 0, 0, 0);
    step(0, 32'h21C, 0, 0, 32'h0,    32'h0,        32'h0,        0, 0,   1, 32'h21C,  0, 2, 0, 0, 0, 0);
    // reset with a fetch pending behind a stalled load
    step(0, 32'h220, 1, 0, 32'h5000, 32'h0,        32'h0,        0, 0,   1, 32'h5000, 0, 0, 0, 0, 0, 0);
    step(0, 32'h220, 0, 0, 32'h0,    32'h0,        32'h0,        1, 0,   1, 32'h220,  0, 2, 1, 1, 0, 0);
    step(1, 32'h220, 0, 0, 32'h0,    32'h0,        32'h0,        1, 0,   0, 32'h0,    0, 0, 1, 1, 0, 0);
    step(1, 32'h300, 0, 0, 32'h0,    32'h0,        32'h0,        1, 1,   0, 32'h0,    0, 0, 0, 0, 0, 0);
    step(0, 32'h300, 0, 0, 32'h0,    32'h0,        32'h0,        0, 0,   1, 32'h300,  0, 2, 0, 0, 0, 0);
    step(0, 32'h304, 0, 0, 32'h0,    32'h0,        32'h88888888, 0, 0,   1, 32'h304,  0, 2, 0, 0, 0, 0);
    // reset with a load pending behind a stalled fetch
    step(0, 32'h308, 1, 0, 32'h6000, 32'h0,        32'h0,        1, 0,   1, 32'h6000, 0, 0, 1, 0, 0, 0);
    step(1, 32'h308, 0, 0, 32'h0,    32'h0,        32'h0,        1, 0,   0, 32'h0,    0, 0, 1, 1, 0, 0);
    step(1, 32'h400, 0, 0, 32'h0,    32'h0,        32'h0,        1, 1,   0, 32'h0,    0, 0, 0, 0, 0, 0);
    step(0, 32'h400, 0, 0, 32'h0,    32'h0,        32'h0,        0, 0,   1, 32'h400,  0, 2, 0, 0, 0, 0);
    step(0, 32'h404, 1, 0, 32'h7000, 32'h0,        32'h99999999, 0, 0,   1, 32'h7000, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
